// File: rtl/usb_tx_pkg.sv
// Shared types for the full-speed USB transmit path:
// line states, FSM states, SYNC pattern and stuff limit.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    LINE_SE0 = 2'd0,
    LINE_J   = 2'd1,
    LINE_K   = 2'd2
  } line_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP
  } tx_state_t;

  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam logic [2:0] STUFF_LIMIT  = 3'd6;

  function automatic line_t nrzi(
    input line_t cur,
    input logic  b
  );
    if (b) return cur;
    return (cur == LINE_J) ? LINE_K : LINE_J;
  endfunction

  // {dp, dn}; low speed swaps J and K
  function automatic logic [1:0] line_drive(
    input line_t l,
    input logic  ls
  );
    logic [1:0] d;
    d = 2'b00;
    case (l)
      LINE_J:  d = ls ? 2'b01 : 2'b10;
      LINE_K:  d = ls ? 2'b10 : 2'b01;
      default: d = 2'b00;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/usb_bit_timer.sv
// Bit-time strobe: counts clocks within one USB bit
// while the transmitter is busy, held at zero otherwise.
module usb_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic bit_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = en && (cnt == LAST);

endmodule

// File: rtl/usb_tx.sv
// USB transmit serializer: SYNC, LSB-first shift,
// bit stuffing, NRZI and EOP onto registered D+/D-.
module usb_tx
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter bit LOW_SPEED    = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_active,
  output logic       usb_dp,
  output logic       usb_dn,
  output logic       usb_oe
);

  tx_state_t  state, state_n;
  logic [7:0] shreg, shreg_n;
  logic [2:0] bit_idx, idx_n;
  logic [2:0] ones, ones_n;
  line_t      line, line_n;
  logic [1:0] eop_cnt, eop_n;
  logic       ready_n, active_n, oe_n;
  logic       send, nbit;
  logic       bit_end;

  usb_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (state != ST_IDLE),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      ones      <= '0;
      line      <= LINE_J;
      eop_cnt   <= '0;
      tx_ready  <= 1'b0;
      tx_active <= 1'b0;
      usb_oe    <= 1'b0;
      {usb_dp, usb_dn} <= line_drive(LINE_J, LOW_SPEED);
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bit_idx   <= idx_n;
      ones      <= ones_n;
      line      <= line_n;
      eop_cnt   <= eop_n;
      tx_ready  <= ready_n;
      tx_active <= active_n;
      usb_oe    <= oe_n;
      {usb_dp, usb_dn} <= line_drive(line_n, LOW_SPEED);
    end
  end

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    idx_n    = bit_idx;
    ones_n   = ones;
    line_n   = line;
    eop_n    = eop_cnt;
    ready_n  = 1'b0;
    active_n = tx_active;
    oe_n     = usb_oe;
    send     = 1'b0;
    nbit     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        line_n   = LINE_J;
        active_n = 1'b0;
        oe_n     = 1'b0;
        if (tx_valid) begin
          state_n  = ST_SYNC;
          shreg_n  = SYNC_PATTERN;
          idx_n    = '0;
          ones_n   = '0;
          send     = 1'b1;
          nbit     = SYNC_PATTERN[0];
          active_n = 1'b1;
          oe_n     = 1'b1;
        end
      end
      ST_SYNC, ST_DATA: begin
        if (bit_end) begin
          // a pending stuff bit wins over the byte boundary
          if (ones == STUFF_LIMIT) begin
            line_n = nrzi(line, 1'b0);
            ones_n = '0;
          end else if (bit_idx != 3'd7) begin
            idx_n   = bit_idx + 3'd1;
            shreg_n = {1'b0, shreg[7:1]};
            send    = 1'b1;
            nbit    = shreg[1];
          end else if (tx_valid) begin
            state_n = ST_DATA;
            shreg_n = tx_data;
            idx_n   = '0;
            ready_n = 1'b1;
            send    = 1'b1;
            nbit    = tx_data[0];
          end else begin
            state_n = ST_EOP;
            line_n  = LINE_SE0;
            eop_n   = '0;
          end
        end
      end
      ST_EOP: begin
        if (bit_end) begin
          if (eop_cnt == 2'd2) begin
            state_n  = ST_IDLE;
            line_n   = LINE_J;
            eop_n    = '0;
            active_n = 1'b0;
            oe_n     = 1'b0;
          end else begin
            eop_n  = eop_cnt + 2'd1;
            line_n = (eop_cnt == 2'd1) ? LINE_J : LINE_SE0;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (send) begin
      line_n = nrzi(line_n, nbit);
      ones_n = nbit ? ones_n + 3'd1 : 3'd0;
    end
  end

endmodule
